register_writeback: RTL and testbench

- Writeback end of the register-read interface: owns the 16 x 64-bit architectural register file and drives it to the read stage.
- Commits results from execute, including the second destination of two-register results (IMUL RDX:RAX), over two cycles.
- Keeps a per-register busy scoreboard, set on read-stage issue and cleared on commit.
- Generates the read-stage stall (operand hazard) and the writeback stall (second-destination commit in progress).

---
 rtl/register_writeback.sv | 112 +++++++++++
 tb/tb_register_writeback.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_writeback.sv
// Writeback end of the register-read interface: architectural register file,
// two-cycle commit of two-destination results, busy scoreboard and stalls.
module register_writeback #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned REG_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic                                 wbValidIn,
  input  logic                                 wbRegValidIn,
  input  logic [3:0]                           wbRegIn,
  input  logic [REG_WIDTH-1:0]                 wbValueIn,
  input  logic                                 wbSpecialValidIn,
  input  logic [3:0]                           wbSpecialRegIn,
  input  logic [REG_WIDTH-1:0]                 wbSpecialValueIn,
  input  logic                                 issueValidIn,
  input  logic                                 issueDestValidIn,
  input  logic [3:0]                           issueDestRegIn,
  input  logic                                 issueSpecialValidIn,
  input  logic [3:0]                           issueSpecialRegIn,
  input  logic                                 checkSrc1ValidIn,
  input  logic [3:0]                           checkSrc1In,
  input  logic                                 checkSrc2ValidIn,
  input  logic [3:0]                           checkSrc2In,
  input  logic                                 checkDestValidIn,
  input  logic [3:0]                           checkDestIn,
  output logic [NUM_REGS-1:0][REG_WIDTH-1:0]   registerFileOut,
  output logic [NUM_REGS-1:0]                  busyMaskOut,
  output logic                                 stallOut,
  output logic                                 wbStallOut,
  output logic [63:0]                          retiredCountOut
);

  localparam int unsigned COUNT_W = 64;

  typedef enum logic [0:0] {
    IDLE          = 1'b0,
    WRITE_SPECIAL = 1'b1
  } state_t;

  state_t                               state, state_next;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]   regs_next;
  logic [NUM_REGS-1:0]                  busy_next;
  logic [COUNT_W-1:0]                   count_next;
  logic [3:0]                           held_reg, held_reg_next;
  logic [REG_WIDTH-1:0]                 held_val, held_val_next;

  // State and storage registers
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state           <= IDLE;
      registerFileOut <= '0;
      busyMaskOut     <= '0;
      retiredCountOut <= '0;
      held_reg        <= '0;
      held_val        <= '0;
    end else begin
      state           <= state_next;
      registerFileOut <= regs_next;
      busyMaskOut     <= busy_next;
      retiredCountOut <= count_next;
      held_reg        <= held_reg_next;
      held_val        <= held_val_next;
    end
  end

  // Commit sequencing; scoreboard sets are applied last so a new producer wins
  always_comb begin
    state_next    = state;
    regs_next     = registerFileOut;
    busy_next     = busyMaskOut;
    count_next    = retiredCountOut;
    held_reg_next = held_reg;
    held_val_next = held_val;

    case (state)
      IDLE: begin
        if (wbValidIn) begin
          count_next = retiredCountOut + COUNT_W'(1);
          if (wbRegValidIn) begin
            regs_next[wbRegIn] = wbValueIn;
            busy_next[wbRegIn] = 1'b0;
          end
          if (wbSpecialValidIn) begin
            held_reg_next = wbSpecialRegIn;
            held_val_next = wbSpecialValueIn;
            state_next    = WRITE_SPECIAL;
          end
        end
      end
      WRITE_SPECIAL: begin
        regs_next[held_reg] = held_val;
        busy_next[held_reg] = 1'b0;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (issueValidIn) begin
      if (issueDestValidIn)    busy_next[issueDestRegIn]    = 1'b1;
      if (issueSpecialValidIn) busy_next[issueSpecialRegIn] = 1'b1;
    end
  end

  assign wbStallOut = (state == WRITE_SPECIAL);

  // No bypass: a dependent read waits until busy has dropped
  assign stallOut = (checkSrc1ValidIn & busyMaskOut[checkSrc1In]) |
                    (checkSrc2ValidIn & busyMaskOut[checkSrc2In]) |
                    (checkDestValidIn & busyMaskOut[checkDestIn]);

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback; expectations are queued with the
// stimulus and drained against the DUT after each step.
module tb_register_writeback;

  localparam int K_REG   = 0;
  localparam int K_BUSY  = 1;
  localparam int K_COUNT = 2;
  localparam int K_STALL = 3;
  localparam int K_WBST  = 4;

  logic              clk = 1'b0;
  logic              resetN;
  logic              wbValidIn, wbRegValidIn, wbSpecialValidIn;
  logic [3:0]        wbRegIn, wbSpecialRegIn;
  logic [63:0]       wbValueIn, wbSpecialValueIn;
  logic              issueValidIn, issueDestValidIn, issueSpecialValidIn;
  logic [3:0]        issueDestRegIn, issueSpecialRegIn;
  logic              checkSrc1ValidIn, checkSrc2ValidIn, checkDestValidIn;
  logic [3:0]        checkSrc1In, checkSrc2In, checkDestIn;
  logic [15:0][63:0] registerFileOut;
  logic [15:0]       busyMaskOut;
  logic              stallOut, wbStallOut;
  logic [63:0]       retiredCountOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  register_writeback dut (
    .clk(clk), .resetN(resetN),
    .wbValidIn(wbValidIn), .wbRegValidIn(wbRegValidIn), .wbRegIn(wbRegIn),
    .wbValueIn(wbValueIn), .wbSpecialValidIn(wbSpecialValidIn),
    .wbSpecialRegIn(wbSpecialRegIn), .wbSpecialValueIn(wbSpecialValueIn),
    .issueValidIn(issueValidIn), .issueDestValidIn(issueDestValidIn),
    .issueDestRegIn(issueDestRegIn), .issueSpecialValidIn(issueSpecialValidIn),
    .issueSpecialRegIn(issueSpecialRegIn),
    .checkSrc1ValidIn(checkSrc1ValidIn), .checkSrc1In(checkSrc1In),
    .checkSrc2ValidIn(checkSrc2ValidIn), .checkSrc2In(checkSrc2In),
    .checkDestValidIn(checkDestValidIn), .checkDestIn(checkDestIn),
    .registerFileOut(registerFileOut), .busyMaskOut(busyMaskOut),
    .stallOut(stallOut), .wbStallOut(wbStallOut),
    .retiredCountOut(retiredCountOut)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] observe(input int kind, input int idx);
    case (kind)
      K_REG:   return registerFileOut[idx];
      K_BUSY:  return {48'd0, busyMaskOut};
      K_COUNT: return retiredCountOut;
      K_STALL: return {63'd0, stallOut};
      default: return {63'd0, wbStallOut};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input int idx,
                            input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.idx);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_idle();
    wbValidIn = 0; wbRegValidIn = 0; wbSpecialValidIn = 0;
    wbRegIn = '0; wbSpecialRegIn = '0; wbValueIn = '0; wbSpecialValueIn = '0;
  endtask

  task automatic wb_drive(input logic [3:0] r, input logic [63:0] v,
                          input logic sp, input logic [3:0] sr,
                          input logic [63:0] sv);
    wbValidIn = 1; wbRegValidIn = 1; wbRegIn = r; wbValueIn = v;
    wbSpecialValidIn = sp; wbSpecialRegIn = sr; wbSpecialValueIn = sv;
  endtask

  task automatic issue_idle();
    issueValidIn = 0; issueDestValidIn = 0; issueSpecialValidIn = 0;
    issueDestRegIn = '0; issueSpecialRegIn = '0;
  endtask

  initial begin
    resetN = 0;
    wb_idle();
    issue_idle();
    checkSrc1ValidIn = 0; checkSrc2ValidIn = 0; checkDestValidIn = 0;
    checkSrc1In = '0; checkSrc2In = '0; checkDestIn = '0;

    // Reset held two cycles
    tick(); tick();
    for (int r = 0; r < 16; r++) expect_val($sformatf("rst_reg%0d", r), K_REG, r, 64'd0);
    expect_val("rst_busy", K_BUSY, 0, 64'd0);
    expect_val("rst_count", K_COUNT, 0, 64'd0);
    expect_val("rst_wbstall", K_WBST, 0, 64'd0);
    drain();

    // Single-destination commit
    resetN = 1;
    wb_drive(4'd3, 64'hDEADBEEF, 1'b0, 4'd0, 64'd0);
    expect_val("first_reg3", K_REG, 3, 64'hDEADBEEF);
    expect_val("first_count", K_COUNT, 0, 64'd1);
    expect_val("first_wbstall", K_WBST, 0, 64'd0);
    tick(); wb_idle(); drain();

    // Two-destination commit
    wb_drive(4'd0, 64'h10, 1'b1, 4'd2, 64'h20);
    expect_val("dual_reg0", K_REG, 0, 64'h10);
    expect_val("dual_reg2_pending", K_REG, 2, 64'd0);
    expect_val("dual_wbstall_on", K_WBST, 0, 64'd1);
    expect_val("dual_count1", K_COUNT, 0, 64'd2);
    tick(); wb_idle(); drain();
    expect_val("dual_reg2", K_REG, 2, 64'h20);
    expect_val("dual_wbstall_off", K_WBST, 0, 64'd0);
    expect_val("dual_count2", K_COUNT, 0, 64'd2);
    tick(); drain();

    // Hazard on reg5
    issueValidIn = 1; issueDestValidIn = 1; issueDestRegIn = 4'd5;
    expect_val("haz_busy", K_BUSY, 0, 64'h0020);
    tick(); issue_idle(); drain();
    checkSrc1ValidIn = 1; checkSrc1In = 4'd5; #1;
    expect_val("haz_stall_src1", K_STALL, 0, 64'd1);
    drain();
    wb_drive(4'd5, 64'h55, 1'b0, 4'd0, 64'd0);
    #1;
    expect_val("haz_stall_before_commit", K_STALL, 0, 64'd1);
    drain();
    expect_val("haz_stall_cleared", K_STALL, 0, 64'd0);
    expect_val("haz_reg5", K_REG, 5, 64'h55);
    expect_val("haz_busy_cleared", K_BUSY, 0, 64'd0);
    tick(); wb_idle(); drain();
    checkSrc1ValidIn = 0;

    // Source-2 and destination-operand hazards
    issueValidIn = 1; issueDestValidIn = 1; issueDestRegIn = 4'd9;
    issueSpecialValidIn = 1; issueSpecialRegIn = 4'd11;
    expect_val("pair_busy", K_BUSY, 0, 64'h0A00);
    tick(); issue_idle(); drain();
    checkSrc2ValidIn = 1; checkSrc2In = 4'd11; #1;
    expect_val("src2_stall", K_STALL, 0, 64'd1);
    drain();
    checkSrc2ValidIn = 0; checkDestValidIn = 1; checkDestIn = 4'd9; #1;
    expect_val("dest_stall", K_STALL, 0, 64'd1);
    drain();
    checkDestValidIn = 0; checkSrc1ValidIn = 1; checkSrc1In = 4'd4; #1;
    expect_val("free_reg_no_stall", K_STALL, 0, 64'd0);
    drain();
    checkSrc1ValidIn = 0;

    // Same-cycle set and clear of reg7: set wins
    wb_drive(4'd7, 64'h77, 1'b0, 4'd0, 64'd0);
    issueValidIn = 1; issueDestValidIn = 1; issueDestRegIn = 4'd7;
    expect_val("coll_reg7", K_REG, 7, 64'h77);
    expect_val("coll_busy", K_BUSY, 0, 64'h0A80);
    expect_val("coll_count", K_COUNT, 0, 64'd4);
    tick(); wb_idle(); issue_idle(); drain();

    // Requests presented during the special-write cycle are ignored
    wb_drive(4'd9, 64'h99, 1'b1, 4'd11, 64'hBB);
    expect_val("ign_reg9", K_REG, 9, 64'h99);
    expect_val("ign_busy1", K_BUSY, 0, 64'h0880);
    expect_val("ign_wbstall", K_WBST, 0, 64'd1);
    expect_val("ign_count1", K_COUNT, 0, 64'd5);
    tick(); drain();
    wb_drive(4'd1, 64'hAA, 1'b0, 4'd0, 64'd0);
    expect_val("ign_reg1_unchanged", K_REG, 1, 64'd0);
    expect_val("ign_count_held", K_COUNT, 0, 64'd5);
    expect_val("ign_reg11", K_REG, 11, 64'hBB);
    expect_val("ign_busy2", K_BUSY, 0, 64'h0080);
    tick(); drain();
    expect_val("held_req_reg1", K_REG, 1, 64'hAA);
    expect_val("held_req_count", K_COUNT, 0, 64'd6);
    tick(); wb_idle(); drain();

    // Same register in both destinations: special value is final
    wb_drive(4'd4, 64'h1, 1'b1, 4'd4, 64'h2);
    expect_val("same_reg4_primary", K_REG, 4, 64'h1);
    tick(); wb_idle(); drain();
    expect_val("same_reg4_final", K_REG, 4, 64'h2);
    expect_val("same_count", K_COUNT, 0, 64'd7);
    tick(); drain();

    // Reset while the second write is held
    wb_drive(4'd6, 64'h66, 1'b1, 4'd8, 64'h88);
    expect_val("rs_reg6", K_REG, 6, 64'h66);
    expect_val("rs_wbstall", K_WBST, 0, 64'd1);
    tick(); wb_idle(); drain();
    resetN = 0;
    expect_val("rs_reg8_dropped", K_REG, 8, 64'd0);
    expect_val("rs_reg6_cleared", K_REG, 6, 64'd0);
    expect_val("rs_wbstall_off", K_WBST, 0, 64'd0);
    expect_val("rs_count", K_COUNT, 0, 64'd0);
    expect_val("rs_busy", K_BUSY, 0, 64'd0);
    tick(); drain();
    resetN = 1;
    expect_val("rs_reg8_after", K_REG, 8, 64'd0);
    expect_val("rs_wbstall_after", K_WBST, 0, 64'd0);
    tick(); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
